icache_arbiter: RTL and testbench
=================================

# icache_arbiter

Shares one instruction cache port among `NUM_REQ` fetch units. Each fetch unit issues single-cycle `request_t` fetches into a one-entry holding slot. The arbiter selects among full slots round-robin whenever the icache is not busy, tags each request with the requester index in `access_id`, and routes icache responses back to the owning fetch unit by that tag. It sits between the per-thread fetch units and the icache and tracks in-flight fetches per requester.

## Interface
Parameters:
- `NUM_REQ`, 4: number of fetch requesters; 2..8.
- `MAX_OUTSTANDING`, 4: maximum in-flight icache requests per requester; 1..15.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester tag in `access_id` low bits.

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `fetch_req[NUM_REQ]` input `request_t`: per-requester fetch request, valid for one cycle when `.vld`=1.
- `fetch_busy` output `[NUM_REQ-1:0]`: bit i high means slot i is full; requester i must not issue.
- `fetch_rsp[NUM_REQ]` output `request_t`: per-requester response, `.vld` pulse for one cycle.
- `icache_busy` input 1: icache cannot accept a request this cycle.
- `icache_req` output `request_t`: arbitrated request to the icache, `.vld` pulse.
- `icache_rsp` input `request_t`: icache response; `access_id[ID_W-1:0]` carries the requester tag.
- `err_overflow` output `[NUM_REQ-1:0]`: sticky; a request arrived while its slot was full.
- `err_unexp_rsp` output 1: sticky; response with an invalid tag or zero outstanding count.

## Operation
- Per requester: slot register (`request_t`) plus `slot_full`, and outstanding counter `out_cnt[i]` (0..`MAX_OUTSTANDING`).
- Capture: `fetch_req[i].vld` && !`slot_full[i]` stores the request; `slot_full[i]`←1.
- Overflow: `fetch_req[i].vld` && `slot_full[i]` drops the new request, keeps the old one, and sets `err_overflow[i]`.
- `fetch_busy[i]` = `slot_full[i]` (combinational from state).
- Eligibility: slot i is eligible when `slot_full[i]` && `out_cnt[i]` < `MAX_OUTSTANDING`.
- Grant:
  - Condition: !`icache_busy` and at least one slot is eligible.
  - Pick the first eligible slot searching upward from `last_grant`+1, wrapping modulo `NUM_REQ`.
  - Update `last_grant`←winner.
- On grant, next cycle `icache_req` = slot contents with `access_id`←winner index (upper bits 0) and `.vld`=1.
  - Same edge: `slot_full[winner]`←0 and `out_cnt[winner]`+1.
  - No grant: `icache_req`←0.
- Response:
  - `icache_rsp.vld` with tag t < `NUM_REQ` and `out_cnt[t]`>0: next cycle `fetch_rsp[t]` = `icache_rsp` with `access_id`←0; `out_cnt[t]`−1.
  - All other `fetch_rsp` outputs are 0.
  - Tag ≥ `NUM_REQ` or `out_cnt[t]`==0: response dropped; `err_unexp_rsp`←1.
- Simultaneous grant and response for the same requester: `out_cnt` unchanged.
- Simultaneous capture and grant-free of the same slot cannot occur, because busy is high while full.
- Errors clear only on reset.

## Timing
- Reset (async, `reset`=0) clears all slots, counters and errors.
  - `last_grant`←`NUM_REQ`−1, so requester 0 wins first.
  - `icache_req`=0, every `fetch_rsp`=0, `fetch_busy`=0, `err_*`=0.
- Reset mid-operation discards slot contents and in-flight counts. Late responses after reset raise `err_unexp_rsp`.
- Latency:
  - Request at cycle T is captured at edge T+1.
  - Earliest grant is decided in cycle T+1; `icache_req.vld` appears in cycle T+2.
  - Slot is free (`fetch_busy` low) from T+2.
- Response at cycle R appears on `fetch_rsp` in cycle R+1.
- Throughput: at most one `icache_req` per cycle. While `icache_busy` stays high, no `icache_req.vld`.

## Structure
- Package: `request_t`, `ADDR_FIELD_WIDTH` and the access-type enum already exist there; add `NUM_FETCH_UNITS` and `ICACHE_MAX_OUTSTANDING` constants.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs: `req[N]`, `advance`.
  - Outputs: one-hot `gnt`, `gnt_idx`.
  - Holds the `last_grant` pointer; reusable for the data-cache port.

## Test plan
- Single requester: `fetch_req[0]` addr 0x100 at T → `icache_req` addr 0x100, `access_id`=0 at T+2; `icache_rsp` data 0xDEAD_BEEF_0000_0001 tag 0 at R → `fetch_rsp[0].data` equal at R+1, `out_cnt[0]` back to 0.
- All four requesters issue in the same cycle with `icache_busy`=0 → grants in order 0,1,2,3 on consecutive cycles. Repeat → order stays 0,1,2,3 because the pointer wraps after 3.
- `icache_busy` held high 5 cycles with slots 1 and 2 full → no `icache_req`, `fetch_busy`=4'b0110. On release, requester 1 is granted first, then 2.
- `MAX_OUTSTANDING`=2, requester 0 issues three fetches with no responses → two granted; the third stays in the slot with `fetch_busy[0]`=1. It is granted the cycle after the first response returns.
- Errors:
  - Response with tag 3 while `out_cnt[3]`==0 → `err_unexp_rsp`=1, no `fetch_rsp` pulse.
  - Request to a full slot 2 → `err_overflow[2]`=1, original slot contents issued.
- Assert `reset`=0 with 2 in flight and slot 1 full → all outputs 0 immediately. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/icache_arbiter_pkg.sv
// Shared fetch/icache request types and block-level defaults for the icache arbiter.
package icache_arbiter_pkg;

    localparam int ADDR_FIELD_WIDTH       = 32;
    localparam int DATA_FIELD_WIDTH       = 64;
    localparam int ACCESS_ID_WIDTH        = 4;
    localparam int NUM_FETCH_UNITS        = 4;
    localparam int ICACHE_MAX_OUTSTANDING = 4;

    typedef enum logic [1:0] {
        ACC_FETCH    = 2'd0,
        ACC_PREFETCH = 2'd1,
        ACC_INVAL    = 2'd2
    } access_e;

    typedef struct packed {
        logic                        vld;
        access_e                     acc;
        logic [ACCESS_ID_WIDTH-1:0]  access_id;
        logic [ADDR_FIELD_WIDTH-1:0] addr;
        logic [DATA_FIELD_WIDTH-1:0] data;
    } request_t;

endpackage

// File: rtl/icache_arbiter_rr_arbiter.sv
// Round-robin picker: searches upward from the last winner, wrapping modulo N.
// Pointer only moves when the caller consumes the grant via advance.
module rr_arbiter
    import icache_arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    int               j;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        j       = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(ptr_q) + k) % N;
            if (req[IDX_W'(j)]) begin
                gnt              = '0;
                gnt[IDX_W'(j)]   = 1'b1;
                gnt_idx          = IDX_W'(j);
            end
        end
        ptr_d = advance ? gnt_idx : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= IDX_W'(N - 1);
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/icache_arbiter.sv
// Shares one icache port among NUM_REQ fetch units: one-entry slot per unit,
// round-robin grant, requester-tagged requests and tag-routed responses.
module icache_arbiter
    import icache_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = NUM_FETCH_UNITS,
    parameter int MAX_OUTSTANDING = ICACHE_MAX_OUTSTANDING,
    parameter int ID_W            = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  request_t [NUM_REQ-1:0]   fetch_req,
    output logic     [NUM_REQ-1:0]   fetch_busy,
    output request_t [NUM_REQ-1:0]   fetch_rsp,
    input  logic                     icache_busy,
    output request_t                 icache_req,
    input  request_t                 icache_rsp,
    output logic     [NUM_REQ-1:0]   err_overflow,
    output logic                     err_unexp_rsp
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    request_t [NUM_REQ-1:0]            slot_q, slot_d;
    logic     [NUM_REQ-1:0]            full_q, full_d;
    logic     [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
    request_t [NUM_REQ-1:0]            rsp_q, rsp_d;
    request_t                          ireq_q, ireq_d;
    logic     [NUM_REQ-1:0]            ovf_q, ovf_d;
    logic                              unexp_q, unexp_d;

    logic [NUM_REQ-1:0] elig, gnt, take, dec;
    logic [ID_W-1:0]    gnt_idx, rsp_tag;
    logic               advance, tag_ok, rsp_ok;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk     (clk),
        .rst_n   (reset),
        .req     (elig),
        .advance (advance),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = full_q[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
        advance = !icache_busy && (|elig);
        take    = gnt & {NUM_REQ{advance}};

        // The whole access_id must name a real requester, not just its low bits.
        rsp_tag = icache_rsp.access_id[ID_W-1:0];
        tag_ok  = icache_rsp.access_id < ACCESS_ID_WIDTH'(NUM_REQ);
        rsp_ok  = icache_rsp.vld && tag_ok && (cnt_q[rsp_tag] != '0);

        slot_d  = slot_q;
        full_d  = full_q;
        cnt_d   = cnt_q;
        dec     = '0;
        ovf_d   = ovf_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            dec[i]   = rsp_ok && (rsp_tag == ID_W'(i));
            cnt_d[i] = cnt_q[i] + CNT_W'(take[i]) - CNT_W'(dec[i]);
            if (take[i]) begin
                full_d[i] = 1'b0;
            end else if (fetch_req[i].vld && !full_q[i]) begin
                full_d[i] = 1'b1;
                slot_d[i] = fetch_req[i];
            end
            if (fetch_req[i].vld && full_q[i]) ovf_d[i] = 1'b1;
        end

        ireq_d = '0;
        if (advance) begin
            ireq_d           = slot_q[gnt_idx];
            ireq_d.vld       = 1'b1;
            ireq_d.access_id = ACCESS_ID_WIDTH'(gnt_idx);
        end

        rsp_d = '0;
        if (rsp_ok) begin
            rsp_d[rsp_tag]           = icache_rsp;
            rsp_d[rsp_tag].access_id = '0;
        end

        unexp_d = unexp_q | (icache_rsp.vld && !rsp_ok);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q  <= '0;
            full_q  <= '0;
            cnt_q   <= '0;
            rsp_q   <= '0;
            ireq_q  <= '0;
            ovf_q   <= '0;
            unexp_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            full_q  <= full_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
            ireq_q  <= ireq_d;
            ovf_q   <= ovf_d;
            unexp_q <= unexp_d;
        end
    end

    assign fetch_busy    = full_q;
    assign fetch_rsp     = rsp_q;
    assign icache_req    = ireq_q;
    assign err_overflow  = ovf_q;
    assign err_unexp_rsp = unexp_q;

endmodule

// File: tb/tb_icache_arbiter.sv
// Directed bench for icache_arbiter (4 requesters, 2 outstanding per requester).
module tb_icache_arbiter;
    import icache_arbiter_pkg::*;

    localparam int NR = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    request_t [NR-1:0]  fetch_req;
    logic     [NR-1:0]  fetch_busy;
    request_t [NR-1:0]  fetch_rsp;
    logic               icache_busy;
    request_t           icache_req;
    request_t           icache_rsp;
    logic     [NR-1:0]  err_overflow;
    logic               err_unexp_rsp;

    int n_chk = 0;
    int n_fail = 0;

    icache_arbiter #(.NUM_REQ(NR), .MAX_OUTSTANDING(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_req     (fetch_req),
        .fetch_busy    (fetch_busy),
        .fetch_rsp     (fetch_rsp),
        .icache_busy   (icache_busy),
        .icache_req    (icache_req),
        .icache_rsp    (icache_rsp),
        .err_overflow  (err_overflow),
        .err_unexp_rsp (err_unexp_rsp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and drop single-cycle pulses.
    task automatic cyc();
        @(negedge clk);
        fetch_req  = '0;
        icache_rsp = '0;
    endtask

    task automatic issue(input int i, input logic [31:0] a);
        fetch_req[i].vld  = 1'b1;
        fetch_req[i].acc  = ACC_FETCH;
        fetch_req[i].addr = a;
    endtask

    task automatic respond(input logic [3:0] tag, input logic [63:0] d);
        icache_rsp.vld       = 1'b1;
        icache_rsp.access_id = tag;
        icache_rsp.data      = d;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        icache_busy = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    function automatic logic [NR-1:0] rsp_vld();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = fetch_rsp[i].vld;
        return v;
    endfunction

    task automatic chk_grant(input string tag, input int id, input logic [31:0] a);
        check({tag, "_vld"}, icache_req.vld, 1'b1);
        check({tag, "_id"}, icache_req.access_id, 64'(id));
        check({tag, "_addr"}, icache_req.addr, a);
    endtask

    initial begin
        fetch_req = '0;
        icache_rsp = '0;
        icache_busy = 1'b0;

        // Reset state
        do_reset();
        check("rst_ireq", icache_req, 64'h0);
        check("rst_busy", fetch_busy, 64'h0);
        check("rst_rsp", |fetch_rsp, 1'b0);
        check("rst_err", {err_overflow, err_unexp_rsp}, 64'h0);

        // Single requester round trip
        issue(0, 32'h100);
        cyc();
        check("t1_busy", fetch_busy, 4'b0001);
        check("t1_early", icache_req.vld, 1'b0);
        cyc();
        chk_grant("t1_gnt", 0, 32'h100);
        check("t1_free", fetch_busy, 4'b0000);
        check("t1_cnt1", dut.cnt_q[0], 1);
        cyc();
        check("t1_pulse", icache_req.vld, 1'b0);
        respond(4'd0, 64'hDEAD_BEEF_0000_0001);
        cyc();
        check("t1_rvld", rsp_vld(), 4'b0001);
        check("t1_rdata", fetch_rsp[0].data, 64'hDEAD_BEEF_0000_0001);
        check("t1_rid", fetch_rsp[0].access_id, 0);
        check("t1_cnt0", dut.cnt_q[0], 0);
        cyc();
        check("t1_rpulse", rsp_vld(), 4'b0000);

        // All four at once, twice: order 0,1,2,3 both rounds
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NR; i++) issue(i, 32'h200 + 32'(r * 'h100 + i * 'h10));
            cyc();
            check("t2_busy", fetch_busy, 4'b1111);
            for (int i = 0; i < NR; i++) begin
                cyc();
                chk_grant("t2_gnt", i, 32'h200 + 32'(r * 'h100 + i * 'h10));
            end
        end
        cyc();
        check("t2_idle", icache_req.vld, 1'b0);

        // icache busy for 5 cycles with slots 1 and 2 full
        do_reset();
        issue(1, 32'h310);
        issue(2, 32'h320);
        icache_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("t3_hold", icache_req.vld, 1'b0);
            check("t3_busy", fetch_busy, 4'b0110);
        end
        icache_busy = 1'b0;
        cyc();
        chk_grant("t3_g1", 1, 32'h310);
        cyc();
        chk_grant("t3_g2", 2, 32'h320);
        cyc();
        check("t3_done", icache_req.vld, 1'b0);

        // Outstanding limit of 2
        do_reset();
        issue(0, 32'h400);
        cyc();
        cyc();
        chk_grant("t4_a", 0, 32'h400);
        issue(0, 32'h410);
        cyc();
        cyc();
        chk_grant("t4_b", 0, 32'h410);
        issue(0, 32'h420);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("t4_stall", icache_req.vld, 1'b0);
            check("t4_busy", fetch_busy[0], 1'b1);
        end
        respond(4'd0, 64'h1111);
        cyc();
        check("t4_rsp", rsp_vld(), 4'b0001);
        check("t4_nogrant", icache_req.vld, 1'b0);
        cyc();
        chk_grant("t4_c", 0, 32'h420);

        // Errors: unexpected response, overflow
        do_reset();
        respond(4'd3, 64'h5555);
        cyc();
        check("t5_unexp", err_unexp_rsp, 1'b1);
        check("t5_norsp", rsp_vld(), 4'b0000);
        icache_busy = 1'b1;
        issue(2, 32'h520);
        cyc();
        issue(2, 32'h5F0);
        cyc();
        check("t5_ovf", err_overflow, 4'b0100);
        icache_busy = 1'b0;
        cyc();
        chk_grant("t5_orig", 2, 32'h520);
        check("t5_sticky", {err_overflow, err_unexp_rsp}, 5'b01001);

        // Reset mid-operation
        do_reset();
        issue(0, 32'h600);
        cyc();
        cyc();
        issue(0, 32'h610);
        cyc();
        issue(1, 32'h620);
        cyc();
        icache_busy = 1'b1;
        chk_grant("t6_pre", 0, 32'h610);
        check("t6_prebusy", fetch_busy, 4'b0010);
        reset = 1'b0;
        #1;
        check("t6_ireq", icache_req, 64'h0);
        check("t6_busy", fetch_busy, 64'h0);
        check("t6_rsp", |fetch_rsp, 1'b0);
        check("t6_cnt", dut.cnt_q[0], 0);
        cyc();
        reset = 1'b1;
        icache_busy = 1'b0;
        issue(1, 32'h630);
        issue(0, 32'h640);
        cyc();
        cyc();
        chk_grant("t6_first", 0, 32'h640);
        cyc();
        chk_grant("t6_second", 1, 32'h630);
        respond(4'd2, 64'h7777);
        cyc();
        check("t6_late", err_unexp_rsp, 1'b1);
        check("t6_latersp", rsp_vld(), 4'b0000);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
